rsv_sched: RTL and testbench
============================

# rsv_sched

Round-robin scheduler that shares one load/store volume accumulator (capacity CAP units) among NREQ requesters. Each requester asks to fill (store) or drain (load) a quantity; the block grants at most one per cycle and applies a fill/drain hysteresis mode: fill until full, then drain until empty. It sits between requester agents and the shared volume register and owns that register.

## Interface
- NREQ, 4: number of requesters (2..8)
- CAP, 25000: volume capacity in units
- CBITS, 15: volume width; CAP < 2^CBITS
- QBITS, 4: per-request quantity width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  request pending, one bit per requester
- dir  in  NREQ  per requester: 1 = fill, 0 = drain
- qty  in  NREQ*QBITS  per-requester quantity, requester i at bits [i*QBITS +: QBITS]
- gnt  out  NREQ  one-hot grant pulse, registered
- vol  out  CBITS  current volume, registered
- mode  out  1  1 = FILL, 0 = DRAIN
- full  out  1  vol == CAP, registered
- empty  out  1  vol == 0, registered

## Operation
- Reset values: vol=0, mode=FILL, gnt=0, full=0, empty=1, rr pointer=0.
- Eligibility: req[i]=1 and dir[i]==mode. Opposite-direction requests are never granted in the current mode; they stay pending.
- Arbitration: among eligible requesters, pick the first at or after the rr pointer (wrapping at NREQ). Pointer then moves to winner+1 mod NREQ. No eligible requester: gnt=0, pointer unchanged.
- Update on grant: FILL: vol = min(vol+qty, CAP). DRAIN: vol = max(vol-qty, 0). Sum computed at CBITS+1 bits before clamping; no wrap-around.
- qty=0: granted normally, vol unchanged.
- Mode FSM (two states):
  - FILL -> DRAIN when the post-update vol == CAP.
  - DRAIN -> FILL when the post-update vol == 0.
  - Otherwise hold.
- full/empty are derived from the post-update vol and are registered alongside it.

## Timing
- req/dir/qty sampled at rising edge k. gnt, vol, mode, full and empty all change at edge k; gnt is visible in cycle k+1 for exactly one cycle.
- Requester holds req/dir/qty stable until it sees gnt. It deasserts req in the cycle after gnt, or keeps it high for another transfer.
- The same requester may win back-to-back only if no other requester is eligible.
- Mode switches at the same edge as the clamping update. The first opposite-direction grant occurs at the next edge at the earliest.
- Throughput: one grant per cycle maximum.
- Asynchronous reset mid-operation: all state returns to reset values immediately. A grant in flight is lost, and the requester must re-request.

## Configuration
- Macro RSV_SCHED_CLAMP_CNT_EN:
  - Defined: adds output clamp_cnt (16 bits) counting units discarded by saturation in either direction. Resets to 0 and saturates at 0xFFFF.
  - Undefined: no port, no counter, and clamping is silent.

## Structure
- Package rsv_sched_pkg: typedef mode_e {DRAIN=0, FILL=1} and default constants for CAP, CBITS and QBITS.
- Sub-module rsv_rr_arb: combinational round-robin pick (eligible vector, pointer -> one-hot winner, valid), parameterised by NREQ.
- The top level holds the pointer, volume, mode FSM and output registers.

## Test plan
- Reset then idle: vol=0, mode=FILL, empty=1, full=0, gnt=0 for 10 cycles with req=0.
- Fairness: all four requesters fill with qty=1 continuously -> gnt order 0,1,2,3,0,... and vol increments by 1 per cycle.
- Saturation: CAP=20, vol=18, requester 1 fills qty=5 -> vol=20, full=1, mode=DRAIN next cycle; with RSV_SCHED_CLAMP_CNT_EN, clamp_cnt=3.
- Direction blocking: mode=DRAIN, req0 fill and req2 drain qty=4 from vol=10 -> only requester 2 granted, vol=6; requester 0 stays pending with no gnt.
- Hysteresis round trip: drain vol 20 -> 0 in qty=7 steps -> vol 13, 6, 0, then mode=FILL, empty=1, and the pending fill requester is granted the following cycle.
- Reset mid-grant: rst_n low while gnt[2]=1 and vol=9 -> gnt=0, vol=0 and mode=FILL immediately; after release, the first grant goes to the lowest-index eligible requester.

Source files
------------

// File: rtl/rsv_sched_pkg.sv
// rsv_sched_pkg: shared types and default sizing for the rsv_sched volume scheduler.
//   mode_e        : hysteresis mode, DRAIN=0 / FILL=1
//   CAP_DEFAULT   : default volume capacity in units
//   CBITS_DEFAULT : default volume register width
//   QBITS_DEFAULT : default per-request quantity width
package rsv_sched_pkg;

    typedef enum logic {
        DRAIN = 1'b0,
        FILL  = 1'b1
    } mode_e;

    localparam int unsigned CAP_DEFAULT   = 25000;
    localparam int unsigned CBITS_DEFAULT = 15;
    localparam int unsigned QBITS_DEFAULT = 4;

endpackage

// File: rtl/rsv_rr_arb.sv
// rsv_rr_arb: combinational round-robin pick.
//   i_elig  [NREQ]  eligible requesters
//   i_ptr   [PW]    search start position (always < NREQ)
//   o_gnt   [NREQ]  one-hot winner, all zero when nothing is eligible
//   o_idx   [PW]    binary index of the winner
//   o_valid         a winner exists
module rsv_rr_arb
    import rsv_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_idx,
    output logic            o_valid
);

    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [PW-1:0] w_pos;

    // Walk NREQ positions starting at the pointer, wrapping at NREQ; first hit wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = i_ptr;
        for (int off = 0; off < NREQ; off++) begin
            if (!o_valid && i_elig[w_pos]) begin
                o_valid      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
            w_pos = (w_pos == LAST) ? '0 : w_pos + 1'b1;
        end
    end

endmodule

// File: rtl/rsv_sched.sv
// rsv_sched: round-robin scheduler owning a shared fill/drain volume accumulator.
// Grants at most one requester per cycle whose direction matches the current mode;
// the mode fills until the volume reaches CAP, then drains until it reaches 0.
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_req  [NREQ]    request pending per requester
//   i_dir  [NREQ]    per requester: 1 = fill, 0 = drain
//   i_qty  [NREQ*QBITS] quantity, requester i at [i*QBITS +: QBITS]
//   o_gnt  [NREQ]    registered one-hot grant pulse
//   o_vol  [CBITS]   registered volume
//   o_mode           1 = FILL, 0 = DRAIN
//   o_full, o_empty  registered vol == CAP / vol == 0
// Optional (macro RSV_SCHED_CLAMP_CNT_EN):
//   o_clamp_cnt [16] saturating count of units discarded by clamping
module rsv_sched
    import rsv_sched_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned CAP   = CAP_DEFAULT,
    parameter int unsigned CBITS = CBITS_DEFAULT,
    parameter int unsigned QBITS = QBITS_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ-1:0]       i_dir,
    input  logic [NREQ*QBITS-1:0] i_qty,
    output logic [NREQ-1:0]       o_gnt,
    output logic [CBITS-1:0]      o_vol,
    output logic                  o_mode,
    output logic                  o_full,
    output logic                  o_empty
`ifdef RSV_SCHED_CLAMP_CNT_EN
    ,
    output logic [15:0]           o_clamp_cnt
`endif
);

    localparam int unsigned   PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST  = PW'(NREQ - 1);
    localparam logic [CBITS:0] CAP_X = CAP[CBITS:0];
    localparam logic [CBITS-1:0] CAP_C = CAP[CBITS-1:0];

    mode_e            r_mode;
    mode_e            w_mode_nxt;
    logic [CBITS-1:0] r_vol;
    logic [NREQ-1:0]  r_gnt;
    logic             r_full;
    logic             r_empty;
    logic [PW-1:0]    r_ptr;

    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_gnt;
    logic [PW-1:0]    w_idx;
    logic             w_valid;
    logic [QBITS-1:0] w_qty;
    logic [CBITS:0]   w_qty_x;
    logic [CBITS:0]   w_vol_x;
    logic [CBITS:0]   w_sum;
    logic [CBITS:0]   w_diff;
    logic [CBITS-1:0] w_vol_nxt;

    // Only requests matching the current mode compete; the rest wait untouched.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = i_req[i] && (i_dir[i] == r_mode);
        end
    end

    rsv_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_comb begin
        w_qty = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_qty = i_qty[i*QBITS +: QBITS];
            end
        end
    end

    // One extra bit of headroom so the fill sum and the drain borrow are visible before clamping.
    assign w_qty_x = {{(CBITS + 1 - QBITS){1'b0}}, w_qty};
    assign w_vol_x = {1'b0, r_vol};
    assign w_sum   = w_vol_x + w_qty_x;
    assign w_diff  = w_vol_x - w_qty_x;

    always_comb begin
        w_vol_nxt = r_vol;
        if (w_valid) begin
            if (r_mode == FILL) begin
                w_vol_nxt = (w_sum > CAP_X) ? CAP_C : w_sum[CBITS-1:0];
            end else begin
                w_vol_nxt = (w_qty_x > w_vol_x) ? '0 : w_diff[CBITS-1:0];
            end
        end
    end

    // Mode FSM: flips on the same edge that lands the volume on a boundary.
    always_comb begin
        w_mode_nxt = r_mode;
        unique case (r_mode)
            FILL: begin
                if (w_valid && (w_vol_nxt == CAP_C)) begin
                    w_mode_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_valid && (w_vol_nxt == '0)) begin
                    w_mode_nxt = FILL;
                end
            end
            default: w_mode_nxt = FILL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode <= FILL;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vol   <= '0;
            r_gnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ptr   <= '0;
        end else begin
            r_vol   <= w_vol_nxt;
            r_gnt   <= w_gnt;
            r_full  <= (w_vol_nxt == CAP_C);
            r_empty <= (w_vol_nxt == '0);
            if (w_valid) begin
                r_ptr <= (w_idx == LAST) ? '0 : w_idx + 1'b1;
            end
        end
    end

`ifdef RSV_SCHED_CLAMP_CNT_EN
    logic [CBITS:0] w_excess;
    logic [16:0]    w_cnt_sum;
    logic [15:0]    r_clamp_cnt;

    always_comb begin
        w_excess = '0;
        if (w_valid) begin
            if (r_mode == FILL) begin
                w_excess = (w_sum > CAP_X) ? (w_sum - CAP_X) : '0;
            end else begin
                w_excess = (w_qty_x > w_vol_x) ? (w_qty_x - w_vol_x) : '0;
            end
        end
    end

    assign w_cnt_sum = {1'b0, r_clamp_cnt} + 17'(w_excess);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clamp_cnt <= '0;
        end else begin
            r_clamp_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        end
    end

    assign o_clamp_cnt = r_clamp_cnt;
`endif

    assign o_gnt   = r_gnt;
    assign o_vol   = r_vol;
    assign o_mode  = r_mode;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: tb/tb_rsv_sched.sv
// tb_rsv_sched: directed + randomized bench for rsv_sched (CAP=20 so boundaries are hit often).
// Stimulus pushes per-cycle expectations from a behavioural model; a monitor pops and compares.
module tb_rsv_sched;

    localparam int NREQ  = 4;
    localparam int CAP   = 20;
    localparam int CBITS = 15;
    localparam int QBITS = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       dir;
    logic [NREQ*QBITS-1:0] qty;
    logic [NREQ-1:0]       gnt;
    logic [CBITS-1:0]      vol;
    logic                  mode;
    logic                  full;
    logic                  empty;
`ifdef RSV_SCHED_CLAMP_CNT_EN
    logic [15:0]           clamp_cnt;
`endif

    rsv_sched #(
        .NREQ  (NREQ),
        .CAP   (CAP),
        .CBITS (CBITS),
        .QBITS (QBITS)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_dir       (dir),
        .i_qty       (qty),
        .o_gnt       (gnt),
        .o_vol       (vol),
        .o_mode      (mode),
        .o_full      (full),
        .o_empty     (empty)
`ifdef RSV_SCHED_CLAMP_CNT_EN
        ,
        .o_clamp_cnt (clamp_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int gnt;
        int vol;
        int mode;
        int full;
        int empty;
        int clamp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state: plain integers, volume clamped with min/max arithmetic.
    int m_vol   = 0;
    int m_mode  = 1;
    int m_ptr   = 0;
    int m_clamp = 0;
    int m_last  = -1;

    logic [NREQ-1:0]       tr_req;
    logic [NREQ-1:0]       tr_dir;
    logic [NREQ*QBITS-1:0] tr_qty;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack(input int q0, input int q1, input int q2, input int q3);
        return {4'(q3), 4'(q2), 4'(q1), 4'(q0)};
    endfunction

    task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d,
                              input logic [NREQ*QBITS-1:0] q);
        int   win;
        int   amt;
        int   s;
        exp_t e;
        win = -1;
        for (int off = 0; off < NREQ; off++) begin
            int i;
            i = (m_ptr + off) % NREQ;
            if (win < 0 && r[i] && (int'(d[i]) == m_mode)) win = i;
        end
        if (win >= 0) begin
            amt = int'(q[win*QBITS +: QBITS]);
            if (m_mode == 1) begin
                s = m_vol + amt;
                if (s > CAP) begin
                    m_clamp += s - CAP;
                    s = CAP;
                end
            end else begin
                s = m_vol - amt;
                if (s < 0) begin
                    m_clamp += -s;
                    s = 0;
                end
            end
            if (m_clamp > 65535) m_clamp = 65535;
            m_vol = s;
            m_ptr = (win + 1) % NREQ;
            if (m_mode == 1 && m_vol == CAP) m_mode = 0;
            else if (m_mode == 0 && m_vol == 0) m_mode = 1;
        end
        m_last  = win;
        e.gnt   = (win >= 0) ? (1 << win) : 0;
        e.vol   = m_vol;
        e.mode  = m_mode;
        e.full  = (m_vol == CAP) ? 1 : 0;
        e.empty = (m_vol == 0) ? 1 : 0;
        e.clamp = m_clamp;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs mid-cycle and record what the next edge must produce.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d,
                        input logic [NREQ*QBITS-1:0] q);
        @(negedge clk);
        req = r;
        dir = d;
        qty = q;
        model_step(r, d, q);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic new_request(input int i);
        tr_req[i] = 1'b1;
        if (i == 0)      tr_dir[i] = 1'b1;
        else if (i == 3) tr_dir[i] = 1'b0;
        else             tr_dir[i] = 1'($urandom_range(1, 0));
        tr_qty[i*QBITS +: QBITS] = 4'($urandom_range(15, 0));
    endtask

    // Monitor: one expectation per post-reset edge; an unexpected grant is an error.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("gnt", int'(gnt), e.gnt);
                    chk("vol", int'(vol), e.vol);
                    chk("mode", int'(mode), e.mode);
                    chk("full", int'(full), e.full);
                    chk("empty", int'(empty), e.empty);
`ifdef RSV_SCHED_CLAMP_CNT_EN
                    chk("clamp_cnt", int'(clamp_cnt), e.clamp);
`endif
                end else begin
                    chk("idle_gnt", int'(gnt), 0);
                end
            end
        end
    end

    initial begin
        int waited;
        rst_n = 1'b1;
        req   = '0;
        dir   = '0;
        qty   = '0;
        #3 rst_n = 1'b0;
        #2;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_vol", int'(vol), 0);
        chk("rst_mode", int'(mode), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_empty", int'(empty), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        for (int c = 0; c < 10; c++) step(4'b0000, 4'b0000, 16'h0);

        // Fairness: everyone fills 1 unit, grants rotate 0,1,2,3.
        for (int c = 0; c < 12; c++) step(4'b1111, 4'b1111, pack(1, 1, 1, 1));
        settle();
        chk("fair_vol", int'(vol), 12);

        // Saturation: 12 -> 18, then +5 clamps at 20 with 3 units lost.
        step(4'b0010, 4'b0010, pack(0, 6, 0, 0));
        step(4'b0010, 4'b0010, pack(0, 5, 0, 0));
        settle();
        chk("sat_vol", int'(vol), 20);
        chk("sat_full", int'(full), 1);
        chk("sat_mode", int'(mode), 0);
`ifdef RSV_SCHED_CLAMP_CNT_EN
        chk("sat_clamp", int'(clamp_cnt), 3);
`endif

        // Direction blocking: requester 0 fill stays pending while requester 2 drains.
        step(4'b0101, 4'b0001, pack(3, 0, 10, 0));
        step(4'b0101, 4'b0001, pack(3, 0, 4, 0));
        settle();
        chk("blk_gnt", int'(gnt), 4);
        chk("blk_vol", int'(vol), 6);
        step(4'b0101, 4'b0001, pack(3, 0, 6, 0));
        step(4'b0001, 4'b0001, pack(3, 0, 0, 0));
        settle();
        chk("blk_release_gnt", int'(gnt), 1);
        chk("blk_release_vol", int'(vol), 3);

        // Refill to 20 (3 -> 18 -> 20, 13 units clamped), then drain in 7s.
        step(4'b0001, 4'b0001, pack(15, 0, 0, 0));
        step(4'b0001, 4'b0001, pack(15, 0, 0, 0));
        for (int c = 0; c < 3; c++) step(4'b1100, 4'b0100, pack(0, 0, 9, 7));
        settle();
        chk("hyst_vol", int'(vol), 0);
        chk("hyst_empty", int'(empty), 1);
        chk("hyst_mode", int'(mode), 1);
        step(4'b0100, 4'b0100, pack(0, 0, 9, 0));
        settle();
        chk("hyst_fill_gnt", int'(gnt), 4);
        chk("hyst_fill_vol", int'(vol), 9);

        // Reset while gnt[2] is visible: everything clears at once.
        rst_n = 1'b0;
        req   = '0;
        dir   = '0;
        qty   = '0;
        #1;
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_vol", int'(vol), 0);
        chk("mid_rst_mode", int'(mode), 1);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_queue", exp_q.size(), 0);
        exp_q.delete();
        m_vol   = 0;
        m_mode  = 1;
        m_ptr   = 0;
        m_clamp = 0;
        m_last  = -1;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0110, 4'b0110, pack(0, 2, 5, 0));
        settle();
        chk("post_rst_gnt", int'(gnt), 2);
        chk("post_rst_vol", int'(vol), 2);

        // Randomized traffic obeying the hold-until-grant protocol.
        // Requester 0 only fills and 3 only drains, so neither mode can starve forever.
        tr_req = '0;
        tr_dir = '0;
        tr_qty = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (tr_req[i] && (m_last == i)) begin
                    if ($urandom_range(1, 0) == 1) new_request(i);
                    else tr_req[i] = 1'b0;
                end else if (!tr_req[i] && ($urandom_range(99, 0) < 35)) begin
                    new_request(i);
                end
            end
            step(tr_req, tr_dir, tr_qty);
        end
        @(negedge clk);
        req = '0;

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
